// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_loader : streams a length-prefixed program image into RAM while      |
// | holding the CPU in reset; optional XOR checksum via PROG_LOADER_CHECKSUM_EN|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int c_DEPTH = 2 ** ADDR_W;
  // Wide enough to hold both any length byte and the RAM depth itself.
  localparam int c_LEN_W = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                w_accept;
  logic                w_len_bad;
  logic                w_last_byte;
  logic [c_LEN_W-1:0]  w_len_ext;
  logic [ADDR_W-1:0]   w_len_m1;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum;
`endif

  assign w_len_ext   = c_LEN_W'(in_data);
  assign w_len_bad   = (in_data == '0) || (w_len_ext > c_LEN_W'(c_DEPTH));
  assign w_len_m1    = ADDR_W'(in_data - DATA_W'(1));
  // r_last holds N-1, so the index stops at the final address and never wraps.
  assign w_last_byte = (r_idx == r_last);

  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst    = 1'b1;
    w_state_nx = r_state;

    case (r_state)
      S_LEN, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase

    w_accept = in_valid && in_ready;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nx = S_LEN;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          w_state_nx = w_len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && w_last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_state_nx = S_CSUM;
`else
          w_state_nx = S_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_state_nx = (in_data == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_last     <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_ram_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_last <= w_len_m1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_idx;
            r_ram_data <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ in_data;
`endif
            if (!w_last_byte) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// Self-checking bench for prog_loader: vector table, hand-written corner
// sequences and randomized sessions against a queue-based reference model.
module tb_prog_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hold_err = 0;
  bit t_out;
  logic [13:0] wr_q[$];
  int          wc_q[$];
  logic [5:0]  last_a;
  logic [7:0]  last_d;
  logic [7:0]  pl [0:255];

  // Write monitor: records every RAM write and checks address/data hold otherwise.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      last_a = '0;
      last_d = '0;
    end else if (ram_we) begin
      wr_q.push_back({ram_addr, ram_data});
      wc_q.push_back(cyc);
      last_a = ram_addr;
      last_d = ram_data;
    end else if (ram_addr !== last_a || ram_data !== last_d) begin
      hold_err++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (t_out) return;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      t_out = 1'b1;
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    @(negedge clk);
  endtask

  task automatic run_session(input string nm, input logic [7:0] len, input logic [7:0] csum,
                             input int gapmode, input bit rnd_start,
                             input int exp_wr, input bit exp_done);
    int gap;
    int bad;
    wr_q.delete();
    wc_q.delete();
    hold_err = 0;
    t_out    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".busy_len"}, {31'd0, busy}, 32'd1);
    send_byte(len, 0);
    if (len >= 1 && len <= DEPTH) begin
      for (int i = 0; i < int'(len); i++) begin
        gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
        if (rnd_start) start = 1'($urandom_range(0, 1));
        send_byte(pl[i], gap);
        start = 1'b0;
      end
      if (CS) send_byte(csum, (gapmode == 0) ? 0 : 1);
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    chk({nm, ".nwrites"}, wr_q.size(), exp_wr);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i] !== {6'(i), pl[i]}) bad++;
    end
    chk({nm, ".wdata_bad"}, bad, 0);
    if (gapmode == 0 && wc_q.size() > 0) begin
      bad = 0;
      for (int i = 0; i < wc_q.size(); i++) begin
        if (wc_q[i] != wc_q[0] + i) bad++;
      end
      chk({nm, ".bubbles"}, bad, 0);
    end
    chk({nm, ".done"},     {31'd0, done},     {31'd0, exp_done});
    chk({nm, ".err"},      {31'd0, err},      {31'd0, !exp_done});
    chk({nm, ".cpu_rst"},  {31'd0, cpu_rst},  {31'd0, !exp_done});
    chk({nm, ".busy"},     {31'd0, busy},     32'd0);
    chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, ".hold"},     hold_err,          0);
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] first;
    logic [7:0] step;
    logic [7:0] csum;
    int         gap;
    int         exp_wr;
    bit         exp_done;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] x;
    logic [7:0] len;
    logic [7:0] cs;
    bit         ok;

    tbl[0] = '{8'd3,   8'h11, 8'h11, 8'h00, 0, 3,  1'b1};
    tbl[1] = '{8'd0,   8'h00, 8'h00, 8'h00, 0, 0,  1'b0};
    tbl[2] = '{8'd4,   8'h01, 8'h01, 8'h04, 1, 4,  1'b1};
    tbl[3] = '{8'd64,  8'h00, 8'h01, 8'h00, 0, 64, 1'b1};
    tbl[4] = '{8'd2,   8'hA5, 8'h6A, 8'h00, 0, 2,  !CS};
    tbl[5] = '{8'd65,  8'h00, 8'h00, 8'h00, 0, 0,  1'b0};
    tbl[6] = '{8'd255, 8'h00, 8'h00, 8'h00, 0, 0,  1'b0};
    tbl[7] = '{8'd1,   8'h7E, 8'h00, 8'h7E, 2, 1,  1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.ram_we",   {31'd0, ram_we},   32'd0);
    chk("rst.ram_addr", {26'd0, ram_addr}, 32'd0);
    chk("rst.ram_data", {24'd0, ram_data}, 32'd0);
    chk("rst.flags",    {29'd0, busy, done, err}, 32'd0);
    chk("rst.cpu_rst",  {31'd0, cpu_rst},  32'd1);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("idle.ignore_valid", {30'd0, busy, ram_we}, 32'd0);
    chk("idle.cpu_rst",      {31'd0, cpu_rst},      32'd1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 256; i++) pl[i] = 8'(tbl[v].first + 8'(i) * tbl[v].step);
      run_session($sformatf("vec%0d", v), tbl[v].len, tbl[v].csum, tbl[v].gap, 1'b0,
                  tbl[v].exp_wr, tbl[v].exp_done);
    end

    // Reset in the middle of a five-byte load.
    for (int i = 0; i < 256; i++) pl[i] = 8'(8'h40 + 8'(i));
    wr_q.delete();
    t_out = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd5, 0);
    send_byte(pl[0], 0);
    send_byte(pl[1], 0);
    chk("midrst.we_before", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.ram_we",   {31'd0, ram_we},   32'd0);
    chk("midrst.ram_addr", {26'd0, ram_addr}, 32'd0);
    chk("midrst.state",    {28'd0, in_ready, busy, done, err}, 32'd0);
    chk("midrst.cpu_rst",  {31'd0, cpu_rst},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = pl[2];
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    chk("midrst.nwrites", wr_q.size(), 2);
    chk("midrst.idle",    {29'd0, in_ready, busy, cpu_rst}, 32'd1);
    run_session("after_rst", 8'd5, 8'(8'h40 ^ 8'h41 ^ 8'h42 ^ 8'h43 ^ 8'h44), 0, 1'b0, 5, 1'b1);

    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255));
      else len = 8'($urandom_range(1, 64));
      x = '0;
      for (int i = 0; i < 256; i++) begin
        pl[i] = 8'($urandom);
        if (i < int'(len)) x = x ^ pl[i];
      end
      cs = ($urandom_range(0, 2) == 0) ? 8'($urandom) : x;
      ok = (len >= 1) && (len <= DEPTH);
      run_session($sformatf("rnd%0d", s), len, cs, int'($urandom_range(0, 2)), 1'b1,
                  ok ? int'(len) : 0, ok && (!CS || cs == x));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width (64 locations).
REQ-002 SHALL have parameter DATA_W, default 8, RAM/stream byte width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a load session; sampled in IDLE, DONE and ERR only.
REQ-006 SHALL have port in_data  input  DATA_W  stream byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port ram_addr  output  ADDR_W  RAM write address.
REQ-010 SHALL have port ram_data  output  DATA_W  RAM write data.
REQ-011 SHALL have port ram_we  output  1  RAM write enable, one-cycle pulse per byte.
REQ-012 SHALL have port cpu_rst  output  1  hold CPU in reset while loading or after failure.
REQ-013 SHALL have ports busy, done, err  output  1 each  session status flags.

Function
REQ-014 SHALL use FSM states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-015 Handshake: byte accepted only when in_valid and in_ready both high on a rising edge; in_ready high only in LEN, DATA, CSUM.
REQ-016 IDLE/DONE/ERR + start -> LEN; clear index, checksum accumulator, done and err; set cpu_rst.
REQ-017 LEN: accepted byte is length N; N in 1..2^ADDR_W -> DATA; N = 0 or N > 2^ADDR_W -> ERR.
REQ-018 DATA: k-th accepted byte (k from 0) SHALL produce, on the following cycle, ram_we=1, ram_addr=k, ram_data=byte; ram_we=0 otherwise.
REQ-019 Back-to-back accepts (in_valid held high) SHALL write one byte per cycle, no bubbles.
REQ-020 After byte N-1 is accepted: -> CSUM (macro defined) or -> DONE (macro undefined).
REQ-021 The index SHALL never wrap; with N = 2^ADDR_W the last address is 2^ADDR_W-1.
REQ-022 DONE: done=1, cpu_rst=0, busy=0; remain until start.
REQ-023 ERR: err=1, cpu_rst=1, busy=0; remain until start; RAM contents already written are not rolled back.
REQ-024 busy SHALL be 1 exactly in LEN, DATA, CSUM.
REQ-025 start while busy SHALL be ignored.
REQ-026 ram_addr/ram_data SHALL hold their last values when ram_we=0.

Reset
REQ-027 rst SHALL immediately force IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0, err=0, cpu_rst=1.
REQ-028 rst mid-session SHALL abandon the session with no further RAM writes; the next session requires start.
REQ-029 cpu_rst SHALL remain 1 from reset until the first DONE.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: loader XORs all N payload bytes; CSUM state accepts one byte; equal -> DONE, mismatch -> ERR.
REQ-031 Macro PROG_LOADER_CHECKSUM_EN undefined: no CSUM state or accumulator; DATA -> DONE directly after byte N-1.

Verification
REQ-032 Load N=3, bytes 0x11,0x22,0x33, checksum 0x00 (enabled) -> writes addr0=0x11, addr1=0x22, addr2=0x33, done=1, cpu_rst=0.
REQ-033 Length byte 0x00 -> ERR, err=1, cpu_rst=1, no ram_we pulse; then start + valid load -> DONE.
REQ-034 N=64, in_valid held high, bytes 0x00..0x3F -> 64 consecutive ram_we cycles, last addr=63 data=0x3F, no wrap.
REQ-035 (enabled) N=2, bytes 0xA5,0x0F, checksum 0x00 (expected 0xAA) -> both bytes written, err=1, cpu_rst=1.
REQ-036 rst asserted after 2 of 5 data bytes -> ram_we=0 immediately, IDLE, cpu_rst=1; further in_valid ignored until start.
REQ-037 in_valid toggled every other cycle during N=4 load -> exactly 4 writes, addresses 0..3 in order.
